// File: rtl/ssd1306_spi_sink.sv
// SSD1306 panel-side 4-wire SPI receiver: deserializes MOSI, parses commands, emits frame-buffer writes.
// Latency: one i_Clk from the 8th detected SCLK rise to the strobe; optional CS via SSD1306_SINK_CS_EN.
// Backpressure: none, sink always accepts; SCLK must hold each level for at least one i_Clk.
module ssd1306_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_DC,
`ifdef SSD1306_SINK_CS_EN
  input  logic       i_SPI_CS_n,
`endif
  output logic       o_FB_WE,
  output logic [9:0] o_FB_ADDR,
  output logic [7:0] o_FB_DATA,
  output logic       o_Cmd_DV,
  output logic [7:0] o_Cmd_Byte,
  output logic       o_Frame_Done,
  output logic       o_Display_On,
  output logic [7:0] o_Contrast,
  output logic [1:0] o_Addr_Mode
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  typedef enum logic {S_IDLE = 1'b0, S_ARG = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, dc_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, dc_s, cs_s;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q[0] <= i_SPI_Clk;
      mosi_sync_q[0] <= i_SPI_MOSI;
      dc_sync_q[0]   <= i_DC;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        dc_sync_q[i]   <= dc_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

`ifdef SSD1306_SINK_CS_EN
  logic [SYNC_STAGES-1:0] cs_sync_q;
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cs_sync_q <= '1;
    end else begin
      cs_sync_q[0] <= i_SPI_CS_n;
      for (int i = 1; i < SYNC_STAGES; i++) cs_sync_q[i] <= cs_sync_q[i-1];
    end
  end
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
`else
  assign cs_s = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    op_q, op_d;
  logic [1:0]    arg_cnt_q, arg_cnt_d;
  logic [6:0]    arg0_q, arg0_d;
  logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
  logic [PW-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d;
  logic          fb_we_q, fb_we_d, cmd_dv_q, cmd_dv_d, frame_done_q, frame_done_d;
  logic          display_on_q, display_on_d;
  logic [9:0]    fb_addr_q, fb_addr_d;
  logic [7:0]    fb_data_q, fb_data_d, cmd_byte_q, cmd_byte_d, contrast_q, contrast_d;
  logic [1:0]    mode_q, mode_d;
  logic          byte_vld;
  logic [7:0]    byte_dat;

  function automatic logic [CW-1:0] inc_col(input logic [CW-1:0] p, input logic [CW-1:0] s,
                                            input logic [CW-1:0] e);
    return (p == e) ? s : CW'(p + 1'b1);
  endfunction

  function automatic logic [PW-1:0] inc_page(input logic [PW-1:0] p, input logic [PW-1:0] s,
                                             input logic [PW-1:0] e);
    return (p == e) ? s : PW'(p + 1'b1);
  endfunction

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    op_d         = op_q;
    arg_cnt_d    = arg_cnt_q;
    arg0_d       = arg0_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_ptr_d    = col_ptr_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_ptr_d   = page_ptr_q;
    fb_we_d      = 1'b0;
    cmd_dv_d     = 1'b0;
    frame_done_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    cmd_byte_d   = cmd_byte_q;
    display_on_d = display_on_q;
    contrast_d   = contrast_q;
    mode_d       = mode_q;
    byte_vld     = 1'b0;
    byte_dat     = {shift_q, mosi_s};

    // Deselected: framing restarts, but the parser keeps any pending arguments.
    if (cs_s) begin
      bit_cnt_d = 3'd0;
      shift_d   = 7'd0;
    end else if (sclk_s && !sclk_prev_q) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_vld  = (bit_cnt_q == 3'd7);
    end

    if (byte_vld && dc_s) begin
      fb_we_d      = 1'b1;
      fb_addr_d    = {page_ptr_q, col_ptr_q};
      fb_data_d    = byte_dat;
      frame_done_d = (mode_q != 2'd2) && (col_ptr_q == col_end_q) && (page_ptr_q == page_end_q);
      state_d      = S_IDLE;
      arg_cnt_d    = 2'd0;
      case (mode_q)
        2'd0: begin
          col_ptr_d = inc_col(col_ptr_q, col_start_q, col_end_q);
          if (col_ptr_q == col_end_q) page_ptr_d = inc_page(page_ptr_q, page_start_q, page_end_q);
        end
        2'd1: begin
          page_ptr_d = inc_page(page_ptr_q, page_start_q, page_end_q);
          if (page_ptr_q == page_end_q) col_ptr_d = inc_col(col_ptr_q, col_start_q, col_end_q);
        end
        default: col_ptr_d = inc_col(col_ptr_q, col_start_q, col_end_q);
      endcase
    end else if (byte_vld) begin
      cmd_dv_d   = 1'b1;
      cmd_byte_d = byte_dat;
      if (state_q == S_IDLE) begin
        op_d      = byte_dat;
        arg_cnt_d = 2'd0;
        case (byte_dat) inside
          8'h21, 8'h22:                                       arg_cnt_d = 2'd2;
          8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA,
          8'hDB, 8'h8D:                                       arg_cnt_d = 2'd1;
          8'hAE:                                              display_on_d = 1'b0;
          8'hAF:                                              display_on_d = 1'b1;
          [8'hB0:8'hB7]:                                      page_ptr_d = byte_dat[PW-1:0];
          [8'h00:8'h0F]:                                      col_ptr_d[3:0] = byte_dat[3:0];
          [8'h10:8'h17]:                                      col_ptr_d[6:4] = byte_dat[2:0];
          default: ;
        endcase
        if (arg_cnt_d != 2'd0) state_d = S_ARG;
      end else begin
        arg_cnt_d = arg_cnt_q - 2'd1;
        if (arg_cnt_q == 2'd1) state_d = S_IDLE;
        // Window commands commit both bounds together on the second argument.
        case (op_q)
          8'h20: mode_d = (byte_dat[1:0] == 2'd3) ? 2'd2 : byte_dat[1:0];
          8'h81: contrast_d = byte_dat;
          8'h21: begin
            if (arg_cnt_q == 2'd2) begin
              arg0_d = byte_dat[6:0];
            end else begin
              col_start_d = arg0_q[CW-1:0];
              col_end_d   = byte_dat[CW-1:0];
              col_ptr_d   = arg0_q[CW-1:0];
            end
          end
          8'h22: begin
            if (arg_cnt_q == 2'd2) begin
              arg0_d = byte_dat[6:0];
            end else begin
              page_start_d = arg0_q[PW-1:0];
              page_end_d   = byte_dat[PW-1:0];
              page_ptr_d   = arg0_q[PW-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      op_q         <= 8'h00;
      arg_cnt_q    <= 2'd0;
      arg0_q       <= 7'd0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      col_ptr_q    <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      page_ptr_q   <= '0;
      fb_we_q      <= 1'b0;
      cmd_dv_q     <= 1'b0;
      frame_done_q <= 1'b0;
      fb_addr_q    <= 10'd0;
      fb_data_q    <= 8'h00;
      cmd_byte_q   <= 8'h00;
      display_on_q <= 1'b0;
      contrast_q   <= 8'h7F;
      mode_q       <= 2'd2;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      op_q         <= op_d;
      arg_cnt_q    <= arg_cnt_d;
      arg0_q       <= arg0_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_ptr_q    <= col_ptr_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_ptr_q   <= page_ptr_d;
      fb_we_q      <= fb_we_d;
      cmd_dv_q     <= cmd_dv_d;
      frame_done_q <= frame_done_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      cmd_byte_q   <= cmd_byte_d;
      display_on_q <= display_on_d;
      contrast_q   <= contrast_d;
      mode_q       <= mode_d;
    end
  end

  assign o_FB_WE      = fb_we_q;
  assign o_FB_ADDR    = fb_addr_q;
  assign o_FB_DATA    = fb_data_q;
  assign o_Cmd_DV     = cmd_dv_q;
  assign o_Cmd_Byte   = cmd_byte_q;
  assign o_Frame_Done = frame_done_q;
  assign o_Display_On = display_on_q;
  assign o_Contrast   = contrast_q;
  assign o_Addr_Mode  = mode_q;
endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: directed panel scenarios plus a random command/data stream
// checked against an integer-level model of the panel's addressing rules.
module tb_ssd1306_spi_sink;
  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, dc;
  logic       o_FB_WE, o_Cmd_DV, o_Frame_Done, o_Display_On;
  logic [9:0] o_FB_ADDR;
  logic [7:0] o_FB_DATA, o_Cmd_Byte, o_Contrast;
  logic [1:0] o_Addr_Mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ssd1306_spi_sink dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi), .i_DC(dc),
    .o_FB_WE(o_FB_WE), .o_FB_ADDR(o_FB_ADDR), .o_FB_DATA(o_FB_DATA),
    .o_Cmd_DV(o_Cmd_DV), .o_Cmd_Byte(o_Cmd_Byte), .o_Frame_Done(o_Frame_Done),
    .o_Display_On(o_Display_On), .o_Contrast(o_Contrast), .o_Addr_Mode(o_Addr_Mode)
  );

  // Observed strobes, only ever appended to; tests remember where they started.
  int got_addr[$], got_data[$], got_fd[$], got_cmd[$];
  int stray_fd = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_FB_WE) begin
        got_addr.push_back(int'(o_FB_ADDR));
        got_data.push_back(int'(o_FB_DATA));
        got_fd.push_back(int'(o_Frame_Done));
      end else if (o_Frame_Done) begin
        stray_fd++;
      end
      if (o_Cmd_DV) got_cmd.push_back(int'(o_Cmd_Byte));
    end
  end

  // Panel model
  int m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_disp, m_con, m_op, m_need, m_arg0;
  int exp_addr[$], exp_data[$], exp_fd[$], exp_cmd[$];

  function automatic int inc(input int p, input int s, input int e, input int m);
    return (p == e) ? s : (p + 1) % m;
  endfunction

  task automatic model_reset();
    m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
    m_disp = 0; m_con = 127; m_op = 0; m_need = 0; m_arg0 = 0;
    exp_addr.delete(); exp_data.delete(); exp_fd.delete(); exp_cmd.delete();
  endtask

  task automatic model_byte(input bit is_data, input int v);
    int wrap;
    if (is_data) begin
      exp_addr.push_back(m_page * 128 + m_col);
      exp_data.push_back(v);
      exp_fd.push_back((m_mode != 2 && m_col == m_ce && m_page == m_pe) ? 1 : 0);
      m_need = 0;
      if (m_mode == 0) begin
        wrap = (m_col == m_ce);
        m_col = inc(m_col, m_cs, m_ce, 128);
        if (wrap != 0) m_page = inc(m_page, m_ps, m_pe, 8);
      end else if (m_mode == 1) begin
        wrap = (m_page == m_pe);
        m_page = inc(m_page, m_ps, m_pe, 8);
        if (wrap != 0) m_col = inc(m_col, m_cs, m_ce, 128);
      end else begin
        m_col = inc(m_col, m_cs, m_ce, 128);
      end
    end else begin
      exp_cmd.push_back(v);
      if (m_need == 0) begin
        m_op = v;
        if (v == 'h21 || v == 'h22) m_need = 2;
        else if (v == 'h20 || v == 'h81 || v == 'hA8 || v == 'hD3 || v == 'hD5 || v == 'hD9 ||
                 v == 'hDA || v == 'hDB || v == 'h8D) m_need = 1;
        else if (v == 'hAE) m_disp = 0;
        else if (v == 'hAF) m_disp = 1;
        else if (v >= 'hB0 && v <= 'hB7) m_page = v - 'hB0;
        else if (v <= 'h0F) m_col = (m_col / 16) * 16 + v;
        else if (v >= 'h10 && v <= 'h17) m_col = (v - 'h10) * 16 + (m_col % 16);
      end else begin
        if (m_op == 'h20) m_mode = ((v % 4) == 3) ? 2 : (v % 4);
        else if (m_op == 'h81) m_con = v;
        else if (m_op == 'h21 && m_need == 2) m_arg0 = v % 128;
        else if (m_op == 'h21) begin m_cs = m_arg0; m_ce = v % 128; m_col = m_cs; end
        else if (m_op == 'h22 && m_need == 2) m_arg0 = v % 8;
        else if (m_op == 'h22) begin m_ps = m_arg0; m_pe = v % 8; m_page = m_ps; end
        m_need--;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic dc_v, input logic [7:0] b, input int n, input int hp);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      mosi = b[i]; dc = dc_v;
      repeat (hp) @(negedge clk);
      sclk = 1'b1;
      repeat (hp) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc_v, input logic [7:0] b, input int hp);
    send_bits(dc_v, b, 8, hp);
    model_byte(dc_v, int'(b));
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    int wb, cb;
    do_reset();
    wb = got_addr.size(); cb = got_cmd.size();
    repeat (12) @(negedge clk);
    checks++; if (o_Contrast !== 8'h7F) begin failures++; $display("FAIL reset_contrast got=%h exp=7f", o_Contrast); end
    checks++; if (o_Addr_Mode !== 2'd2) begin failures++; $display("FAIL reset_mode got=%0d exp=2", o_Addr_Mode); end
    checks++; if (o_Display_On !== 1'b0) begin failures++; $display("FAIL reset_display got=%b exp=0", o_Display_On); end
    checks++; if (o_FB_ADDR !== 10'd0 || o_FB_DATA !== 8'h00 || o_Cmd_Byte !== 8'h00) begin
      failures++; $display("FAIL reset_regs addr=%0d data=%h cmd=%h exp=0/00/00", o_FB_ADDR, o_FB_DATA, o_Cmd_Byte); end
    checks++; if (o_FB_WE !== 1'b0 || o_Cmd_DV !== 1'b0 || o_Frame_Done !== 1'b0) begin
      failures++; $display("FAIL reset_strobes we=%b dv=%b fd=%b exp=000", o_FB_WE, o_Cmd_DV, o_Frame_Done); end
    checks++; if (got_addr.size() - wb !== 0 || got_cmd.size() - cb !== 0) begin
      failures++; $display("FAIL reset_idle_pulses writes=%0d cmds=%0d exp=0", got_addr.size() - wb, got_cmd.size() - cb); end
  endtask

  task automatic test_full_frame();
    logic [7:0] seq [9] = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};
    int wb, cb;
    do_reset();
    wb = got_addr.size(); cb = got_cmd.size();
    foreach (seq[i]) send_byte(1'b0, seq[i], 2);
    for (int a = 0; a < 1024; a++) send_byte(1'b1, a[7:0], 2);
    drain();
    checks++; if (got_addr.size() - wb !== 1024) begin failures++; $display("FAIL frame_count got=%0d exp=1024", got_addr.size() - wb); end
    if (got_addr.size() - wb == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        checks++; if (got_addr[wb+i] !== i || got_data[wb+i] !== i % 256 || got_fd[wb+i] !== (i == 1023 ? 1 : 0)) begin
          failures++; $display("FAIL frame_write[%0d] addr=%0d data=%0d fd=%0d exp=%0d/%0d/%0d",
                               i, got_addr[wb+i], got_data[wb+i], got_fd[wb+i], i, i % 256, (i == 1023 ? 1 : 0)); end
      end
    end
    checks++; if (o_Display_On !== 1'b1) begin failures++; $display("FAIL frame_display got=%b exp=1", o_Display_On); end
    checks++; if (got_cmd.size() - cb !== 9) begin failures++; $display("FAIL frame_cmd_pulses got=%0d exp=9", got_cmd.size() - cb); end
  endtask

  task automatic test_window();
    logic [7:0] seq [8] = '{8'h21, 8'h7E, 8'h7F, 8'h22, 8'h06, 8'h07, 8'h20, 8'h00};
    int ea [5] = '{894, 895, 1022, 1023, 894};
    int ed [5];
    int wb;
    wb = got_addr.size();
    foreach (seq[i]) send_byte(1'b0, seq[i], $urandom_range(2, 3));
    for (int i = 0; i < 5; i++) begin
      ed[i] = $urandom_range(0, 255);
      send_byte(1'b1, ed[i][7:0], $urandom_range(2, 3));
    end
    drain();
    checks++; if (got_addr.size() - wb !== 5) begin failures++; $display("FAIL window_count got=%0d exp=5", got_addr.size() - wb); end
    if (got_addr.size() - wb == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_addr[wb+i] !== ea[i] || got_data[wb+i] !== ed[i] || got_fd[wb+i] !== (i == 3 ? 1 : 0)) begin
          failures++; $display("FAIL window_write[%0d] addr=%0d data=%0d fd=%0d exp=%0d/%0d/%0d",
                               i, got_addr[wb+i], got_data[wb+i], got_fd[wb+i], ea[i], ed[i], (i == 3 ? 1 : 0)); end
      end
    end
  endtask

  task automatic test_page_mode();
    logic [7:0] seq [5] = '{8'h20, 8'h02, 8'hB3, 8'h05, 8'h12};
    int wb;
    do_reset();
    wb = got_addr.size();
    foreach (seq[i]) send_byte(1'b0, seq[i], $urandom_range(2, 3));
    send_byte(1'b1, 8'h3C, 2);
    send_byte(1'b1, 8'hC3, 3);
    drain();
    checks++; if (got_addr.size() - wb !== 2) begin failures++; $display("FAIL page_count got=%0d exp=2", got_addr.size() - wb); end
    if (got_addr.size() - wb == 2) begin
      checks++; if (got_addr[wb] !== 421 || got_addr[wb+1] !== 422) begin
        failures++; $display("FAIL page_addr got=%0d,%0d exp=421,422", got_addr[wb], got_addr[wb+1]); end
      checks++; if (got_fd[wb] !== 0 || got_fd[wb+1] !== 0 || got_data[wb] !== 'h3C || got_data[wb+1] !== 'hC3) begin
        failures++; $display("FAIL page_data fd=%0d,%0d data=%h,%h exp=0,0 3c,c3", got_fd[wb], got_fd[wb+1], got_data[wb], got_data[wb+1]); end
    end
  endtask

  task automatic test_arg_abort();
    int wb, cb;
    do_reset();
    wb = got_addr.size(); cb = got_cmd.size();
    send_byte(1'b0, 8'h81, 2);
    send_byte(1'b1, 8'h55, 3);
    send_byte(1'b0, 8'hAF, 2);
    drain();
    checks++; if (o_Contrast !== 8'h7F) begin failures++; $display("FAIL abort_contrast got=%h exp=7f", o_Contrast); end
    checks++; if (got_addr.size() - wb !== 1) begin failures++; $display("FAIL abort_writes got=%0d exp=1", got_addr.size() - wb); end
    else begin
      checks++; if (got_data[wb] !== 'h55 || got_addr[wb] !== 0) begin
        failures++; $display("FAIL abort_write data=%h addr=%0d exp=55/0", got_data[wb], got_addr[wb]); end
    end
    checks++; if (o_Display_On !== 1'b1) begin failures++; $display("FAIL abort_display got=%b exp=1", o_Display_On); end
    checks++; if (got_cmd.size() - cb !== 2) begin failures++; $display("FAIL abort_cmd_pulses got=%0d exp=2", got_cmd.size() - cb); end
  endtask

  task automatic test_reset_midbyte();
    int wb;
    do_reset();
    send_bits(1'b1, 8'hF0, 4, 2);
    do_reset();
    wb = got_addr.size();
    send_byte(1'b1, 8'hA5, 2);
    drain();
    checks++; if (got_addr.size() - wb !== 1) begin failures++; $display("FAIL midbyte_writes got=%0d exp=1", got_addr.size() - wb); end
    else begin
      checks++; if (got_data[wb] !== 'hA5 || got_addr[wb] !== 0) begin
        failures++; $display("FAIL midbyte_write data=%h addr=%0d exp=a5/0", got_data[wb], got_addr[wb]); end
    end
  endtask

  task automatic test_random_stream();
    int ops [15] = '{'h20, 'h20, 'h21, 'h22, 'h81, 'hAE, 'hAF, 'hB0, 'h00, 'h10, 'hA8, 'h8D, 'hE3, 'h21, 'h22};
    int wb, cb, sfd, n, op;
    do_reset();
    wb = got_addr.size(); cb = got_cmd.size(); sfd = stray_fd;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 5) begin
        send_byte(1'b1, 8'($urandom_range(0, 255)), $urandom_range(2, 3));
      end else begin
        op = ops[$urandom_range(0, 14)];
        if (op == 'hB0) op = op + $urandom_range(0, 7);
        else if (op == 'h00) op = $urandom_range(0, 15);
        else if (op == 'h10) op = op + $urandom_range(0, 7);
        send_byte(1'b0, 8'(op), $urandom_range(2, 3));
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) send_byte(1'b0, 8'($urandom_range(0, 255)), $urandom_range(2, 3));
      end
    end
    drain();
    checks++; if (got_addr.size() - wb !== exp_addr.size()) begin
      failures++; $display("FAIL rand_write_count got=%0d exp=%0d", got_addr.size() - wb, exp_addr.size()); end
    else begin
      foreach (exp_addr[i]) begin
        checks++; if (got_addr[wb+i] !== exp_addr[i] || got_data[wb+i] !== exp_data[i] || got_fd[wb+i] !== exp_fd[i]) begin
          failures++; $display("FAIL rand_write[%0d] addr=%0d data=%0d fd=%0d exp=%0d/%0d/%0d",
                               i, got_addr[wb+i], got_data[wb+i], got_fd[wb+i], exp_addr[i], exp_data[i], exp_fd[i]); end
      end
    end
    checks++; if (got_cmd.size() - cb !== exp_cmd.size()) begin
      failures++; $display("FAIL rand_cmd_count got=%0d exp=%0d", got_cmd.size() - cb, exp_cmd.size()); end
    else begin
      foreach (exp_cmd[i]) begin
        checks++; if (got_cmd[cb+i] !== exp_cmd[i]) begin
          failures++; $display("FAIL rand_cmd[%0d] got=%h exp=%h", i, got_cmd[cb+i], exp_cmd[i]); end
      end
    end
    checks++; if (int'(o_Contrast) !== m_con || int'(o_Addr_Mode) !== m_mode || int'(o_Display_On) !== m_disp) begin
      failures++; $display("FAIL rand_state con=%h mode=%0d disp=%0d exp=%h/%0d/%0d",
                           o_Contrast, o_Addr_Mode, o_Display_On, m_con, m_mode, m_disp); end
    checks++; if (stray_fd - sfd !== 0) begin failures++; $display("FAIL rand_stray_frame_done got=%0d exp=0", stray_fd - sfd); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
    test_reset();
    test_full_frame();
    test_window();
    test_page_mode();
    test_arg_abort();
    test_reset_midbyte();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
